// File: rtl/jt007232_romarb_slot.sv
// jt007232_romarb_slot: one-entry tag/data cache for a single ROM client
module jt007232_romarb_slot #(
  parameter int AW = 17,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  input  logic          wr,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] dout,
  output logic          ok,
  output logic          miss
);
  logic [AW-1:0] tag_q, tag_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  always_comb begin
    tag_d   = wr ? wr_addr : tag_q;
    data_d  = wr ? wr_data : data_q;
    valid_d = wr | valid_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  assign ok   = cs & valid_q & (tag_q == addr);
  assign miss = cs & ~ok;
  assign dout = data_q;
endmodule

// File: rtl/jt007232_romarb.sv
// jt007232_romarb: round-robin arbiter sharing one ROM port between two cached clients
module jt007232_romarb #(
  parameter int AW = 17,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] a_addr,
  input  logic          a_cs,
  output logic [DW-1:0] a_dout,
  output logic          a_ok,
  input  logic [AW-1:0] b_addr,
  input  logic          b_cs,
  output logic [DW-1:0] b_dout,
  output logic          b_ok,
  output logic [AW-1:0] mem_addr,
  output logic          mem_cs,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_ok
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t        state_q;
  logic          owner_q, last_q, armed_q, mem_cs_q;
  logic [AW-1:0] mem_addr_q;
  logic          a_miss, b_miss, grant_b, accept;
  // armed_q masks mem_ok during the first cycle mem_cs is high
  assign accept  = (state_q == WAIT) & armed_q & mem_cs_q & mem_ok;
  assign grant_b = b_miss & (~a_miss | ~last_q);
  jt007232_romarb_slot #(.AW(AW), .DW(DW)) u_a (
    .clk(clk), .rst_n(rst_n), .addr(a_addr), .cs(a_cs),
    .wr(accept & ~owner_q), .wr_addr(mem_addr_q), .wr_data(mem_dout),
    .dout(a_dout), .ok(a_ok), .miss(a_miss)
  );
  jt007232_romarb_slot #(.AW(AW), .DW(DW)) u_b (
    .clk(clk), .rst_n(rst_n), .addr(b_addr), .cs(b_cs),
    .wr(accept & owner_q), .wr_addr(mem_addr_q), .wr_data(mem_dout),
    .dout(b_dout), .ok(b_ok), .miss(b_miss)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      armed_q    <= 1'b0;
      mem_cs_q   <= 1'b0;
      mem_addr_q <= '0;
    end else if (state_q == IDLE) begin
      armed_q <= 1'b0;
      if (a_miss | b_miss) begin
        state_q    <= WAIT;
        owner_q    <= grant_b;
        mem_cs_q   <= 1'b1;
        mem_addr_q <= grant_b ? b_addr : a_addr;
      end
    end else begin
      armed_q <= 1'b1;
      if (accept) begin
        state_q  <= IDLE;
        mem_cs_q <= 1'b0;
        last_q   <= owner_q;
      end
    end
  end
  assign mem_cs   = mem_cs_q;
  assign mem_addr = mem_addr_q;
endmodule

// File: tb/tb_jt007232_romarb.sv
// tb_jt007232_romarb: cycle-by-cycle vector table plus directed corner sequences
module tb_jt007232_romarb;
  logic        clk = 0, rst_n = 0;
  logic [16:0] a_addr = 0, b_addr = 0, mem_addr;
  logic        a_cs = 0, b_cs = 0, a_ok, b_ok, mem_cs, mem_ok = 0;
  logic [7:0]  a_dout, b_dout, mem_dout = 0;
  int checks = 0, failures = 0;

  jt007232_romarb dut (
    .clk(clk), .rst_n(rst_n),
    .a_addr(a_addr), .a_cs(a_cs), .a_dout(a_dout), .a_ok(a_ok),
    .b_addr(b_addr), .b_cs(b_cs), .b_dout(b_dout), .b_ok(b_ok),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_dout(mem_dout), .mem_ok(mem_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst_n; logic a_cs; logic [16:0] a_addr; logic b_cs; logic [16:0] b_addr;
    logic mem_ok; logic [7:0] mem_dout;
    logic e_cs; logic [16:0] e_addr; logic e_aok; logic [7:0] e_adout; logic e_bok; logic [7:0] e_bdout;
  } row_t;

  row_t tbl [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic ac, input logic [16:0] aa,
                      input logic bc, input logic [16:0] ba, input logic mo, input logic [7:0] md);
    rst_n = r; a_cs = ac; a_addr = aa; b_cs = bc; b_addr = ba; mem_ok = mo; mem_dout = md;
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0]  = '{0, 0, 17'h0,     0, 17'h0,     0, 8'h00, 0, 17'h0,     0, 8'h00, 0, 8'h00};
    tbl[1]  = '{0, 0, 17'h0,     0, 17'h0,     0, 8'h00, 0, 17'h0,     0, 8'h00, 0, 8'h00};
    tbl[2]  = '{1, 1, 17'h10,    0, 17'h0,     0, 8'h00, 1, 17'h10,    0, 8'h00, 0, 8'h00};
    tbl[3]  = '{1, 1, 17'h10,    0, 17'h0,     0, 8'h00, 1, 17'h10,    0, 8'h00, 0, 8'h00};
    tbl[4]  = '{1, 1, 17'h10,    0, 17'h0,     0, 8'h00, 1, 17'h10,    0, 8'h00, 0, 8'h00};
    tbl[5]  = '{1, 1, 17'h10,    0, 17'h0,     0, 8'h00, 1, 17'h10,    0, 8'h00, 0, 8'h00};
    tbl[6]  = '{1, 1, 17'h10,    0, 17'h0,     1, 8'h5A, 0, 17'h10,    1, 8'h5A, 0, 8'h00};
    tbl[7]  = '{1, 1, 17'h10,    0, 17'h0,     0, 8'h00, 0, 17'h10,    1, 8'h5A, 0, 8'h00};
    tbl[8]  = '{0, 0, 17'h10,    0, 17'h0,     0, 8'h00, 0, 17'h0,     0, 8'h00, 0, 8'h00};
    tbl[9]  = '{1, 1, 17'h1,     1, 17'h1FFFF, 0, 8'h00, 1, 17'h1,     0, 8'h00, 0, 8'h00};
    tbl[10] = '{1, 1, 17'h1,     1, 17'h1FFFF, 1, 8'h11, 1, 17'h1,     0, 8'h00, 0, 8'h00};
    tbl[11] = '{1, 1, 17'h1,     1, 17'h1FFFF, 1, 8'h11, 0, 17'h1,     1, 8'h11, 0, 8'h00};
    tbl[12] = '{1, 1, 17'h1,     1, 17'h1FFFF, 0, 8'h00, 1, 17'h1FFFF, 1, 8'h11, 0, 8'h00};
    tbl[13] = '{1, 1, 17'h1,     1, 17'h1FFFF, 0, 8'h00, 1, 17'h1FFFF, 1, 8'h11, 0, 8'h00};
    tbl[14] = '{1, 1, 17'h1,     1, 17'h1FFFF, 1, 8'h22, 0, 17'h1FFFF, 1, 8'h11, 1, 8'h22};
    tbl[15] = '{1, 0, 17'h1,     1, 17'h100,   0, 8'h00, 1, 17'h100,   0, 8'h11, 0, 8'h22};
    tbl[16] = '{1, 0, 17'h1,     1, 17'h100,   0, 8'h00, 1, 17'h100,   0, 8'h11, 0, 8'h22};
    tbl[17] = '{1, 0, 17'h1,     1, 17'h100,   1, 8'h33, 0, 17'h100,   0, 8'h11, 1, 8'h33};
    tbl[18] = '{1, 1, 17'h40,    1, 17'h100,   0, 8'h00, 1, 17'h40,    0, 8'h11, 1, 8'h33};
    tbl[19] = '{1, 1, 17'h40,    1, 17'h100,   0, 8'h00, 1, 17'h40,    0, 8'h11, 1, 8'h33};
    tbl[20] = '{1, 1, 17'h40,    1, 17'h100,   0, 8'h00, 1, 17'h40,    0, 8'h11, 1, 8'h33};
    tbl[21] = '{1, 1, 17'h40,    1, 17'h100,   1, 8'h44, 0, 17'h40,    1, 8'h44, 1, 8'h33};
    @(posedge clk); #1;
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].rst_n, tbl[i].a_cs, tbl[i].a_addr, tbl[i].b_cs, tbl[i].b_addr, tbl[i].mem_ok, tbl[i].mem_dout);
      chk($sformatf("row%0d mem_cs", i),   32'(mem_cs),   32'(tbl[i].e_cs));
      chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("row%0d a_ok", i),     32'(a_ok),     32'(tbl[i].e_aok));
      chk($sformatf("row%0d a_dout", i),   32'(a_dout),   32'(tbl[i].e_adout));
      chk($sformatf("row%0d b_ok", i),     32'(b_ok),     32'(tbl[i].e_bok));
      chk($sformatf("row%0d b_dout", i),   32'(b_dout),   32'(tbl[i].e_bdout));
    end
    // address change while waiting: stale result cached, then a fresh miss
    step(1, 1, 17'h20, 0, 17'h0, 0, 8'h00);
    chk("chg grant mem_cs", 32'(mem_cs), 1);
    chk("chg grant mem_addr", 32'(mem_addr), 32'h20);
    step(1, 1, 17'h21, 0, 17'h0, 0, 8'h00);
    chk("chg hold mem_addr", 32'(mem_addr), 32'h20);
    chk("chg hold a_ok", 32'(a_ok), 0);
    step(1, 1, 17'h21, 0, 17'h0, 1, 8'h55);
    chk("chg accept mem_cs", 32'(mem_cs), 0);
    chk("chg accept a_ok", 32'(a_ok), 0);
    chk("chg accept a_dout", 32'(a_dout), 32'h55);
    step(1, 1, 17'h21, 0, 17'h0, 0, 8'h00);
    chk("chg regrant mem_cs", 32'(mem_cs), 1);
    chk("chg regrant mem_addr", 32'(mem_addr), 32'h21);
    // reset in the middle of a wait, then a late mem_ok
    step(1, 1, 17'h21, 0, 17'h0, 0, 8'h00);
    chk("rst pre mem_cs", 32'(mem_cs), 1);
    step(0, 1, 17'h21, 0, 17'h0, 0, 8'h00);
    chk("rst mem_cs", 32'(mem_cs), 0);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst a_dout", 32'(a_dout), 0);
    chk("rst b_dout", 32'(b_dout), 0);
    step(1, 0, 17'h0, 0, 17'h0, 1, 8'h66);
    chk("late ok mem_cs", 32'(mem_cs), 0);
    chk("late ok a_dout", 32'(a_dout), 0);
    a_cs = 1; a_addr = 17'h0; mem_ok = 0; #1;
    chk("late ok valid", 32'(a_ok), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
